// File: rtl/wb_stage_params.sv
// Shared widths and payload structs for the writeback/commit stage.
package wb_stage_params;

  localparam int unsigned PC_W       = 32;
  localparam int unsigned STRB_W     = 4;
  localparam int unsigned EXC_CODE_W = 5;
  localparam int unsigned CP0_REG_W  = 5;
  localparam int unsigned CP0_SEL_W  = 3;

  // Fixed-width per-lane fields; result and register address stay parameter-sized
  typedef struct packed {
    logic [PC_W-1:0]       pc;
    logic [STRB_W-1:0]     strobe;
    logic                  rf_we;
    logic                  mfc0;
    logic                  mtc0;
    logic                  exc;
    logic                  eret;
    logic                  delay_slot;
    logic [EXC_CODE_W-1:0] exc_code;
    logic [CP0_REG_W-1:0]  cp0_reg;
    logic [CP0_SEL_W-1:0]  cp0_sel;
  } lane_ctrl_t;

  typedef struct packed {
    logic                  we;
    logic                  exc_valid;
    logic                  eret;
    logic                  bd;
    logic [CP0_REG_W-1:0]  cp0_reg;
    logic [CP0_SEL_W-1:0]  cp0_sel;
    logic [EXC_CODE_W-1:0] exc_code;
    logic [PC_W-1:0]       exc_pc;
  } cp0_req_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/wb_commit_stage_if.sv
// Incoming commit bundle from the previous stage plus the stage's allow-in handshake.
interface wb_commit_stage_if
  import wb_stage_params::*;
#(
  parameter int unsigned LANES          = 2,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
);
  logic                            io_valid;
  logic                            wb_allow_in;
  logic [LANES-1:0]                io_lane_valid;
  logic [LANES*PC_W-1:0]           io_pc;
  logic [LANES-1:0]                io_rf_we;
  logic [LANES*REG_ADDR_WIDTH-1:0] io_rf_addr;
  logic [LANES*STRB_W-1:0]         io_rf_strobe;
  logic [LANES*DATA_WIDTH-1:0]     io_result;
  logic [LANES-1:0]                io_mfc0;
  logic [LANES-1:0]                io_mtc0;
  logic [LANES-1:0]                io_exc;
  logic [LANES-1:0]                io_eret;
  logic [LANES-1:0]                io_delay_slot;
  logic [LANES*EXC_CODE_W-1:0]     io_exc_code;
  logic [LANES*CP0_REG_W-1:0]      io_cp0_reg;
  logic [LANES*CP0_SEL_W-1:0]      io_cp0_sel;

  modport master (
    output io_valid, io_lane_valid, io_pc, io_rf_we, io_rf_addr, io_rf_strobe, io_result,
           io_mfc0, io_mtc0, io_exc, io_eret, io_delay_slot, io_exc_code, io_cp0_reg, io_cp0_sel,
    input  wb_allow_in
  );

  modport slave (
    input  io_valid, io_lane_valid, io_pc, io_rf_we, io_rf_addr, io_rf_strobe, io_result,
           io_mfc0, io_mtc0, io_exc, io_eret, io_delay_slot, io_exc_code, io_cp0_reg, io_cp0_sel,
    output wb_allow_in
  );
endinterface

// File: rtl/wb_lane_kill.sv
// Live-lane mask (everything younger than the first exc/eret is killed) and oldest CP0 lane.
module wb_lane_kill
  import wb_stage_params::*;
#(
  parameter  int unsigned LANES = 2,
  localparam int unsigned IDX_W = idx_width(LANES)
) (
  input  logic [LANES-1:0] lane_valid,
  input  logic [LANES-1:0] exc,
  input  logic [LANES-1:0] eret,
  input  logic [LANES-1:0] cp0_op,
  output logic [LANES-1:0] live,
  output logic             cp0_hit,
  output logic [IDX_W-1:0] cp0_idx
);

  logic killed;

  always_comb begin
    live    = '0;
    cp0_hit = 1'b0;
    cp0_idx = '0;
    killed  = 1'b0;
    for (int i = 0; i < int'(LANES); i++) begin
      live[i] = lane_valid[i] && !killed;
      if (live[i] && cp0_op[i] && !cp0_hit) begin
        cp0_hit = 1'b1;
        cp0_idx = IDX_W'(i);
      end
      killed = killed || (live[i] && (exc[i] || eret[i]));
    end
  end

endmodule

// File: rtl/wb_commit_stage.sv
// In-order multi-lane writeback/commit stage driving register file, CP0 and flushes.
// Optional WB_RETIRE_COUNTER_EN adds a free-running retired-instruction counter output.
module wb_commit_stage
  import wb_stage_params::*;
#(
  parameter int unsigned LANES          = 2,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                            clock,
  input  logic                            reset,
  wb_commit_stage_if.slave                io,
  input  logic                            cp0_busy,
  input  logic [DATA_WIDTH-1:0]           cp0_read_data,
  output logic                            cp0_we,
  output logic                            cp0_exc_valid,
  output logic                            cp0_eret,
  output logic                            cp0_bd,
  output logic [CP0_REG_W-1:0]            cp0_reg,
  output logic [CP0_SEL_W-1:0]            cp0_sel,
  output logic [EXC_CODE_W-1:0]           cp0_exc_code,
  output logic [PC_W-1:0]                 cp0_exc_pc,
  output logic [DATA_WIDTH-1:0]           cp0_wdata,
  output logic [LANES-1:0]                rf_we,
  output logic [LANES*REG_ADDR_WIDTH-1:0] rf_addr,
  output logic [LANES*STRB_W-1:0]         rf_strobe,
  output logic [LANES*DATA_WIDTH-1:0]     rf_data,
  output logic                            flush_exception,
  output logic                            flush_eret,
  output logic [LANES*PC_W-1:0]           debug_pc,
  output logic [LANES*STRB_W-1:0]         debug_rf_we,
  output logic [LANES*REG_ADDR_WIDTH-1:0] debug_rf_addr,
  output logic [LANES*DATA_WIDTH-1:0]     debug_rf_data
`ifdef WB_RETIRE_COUNTER_EN
  ,
  output logic [31:0]                     retire_count
`endif
);

  localparam int unsigned IDX_W = idx_width(LANES);

  logic                      wb_valid;
  logic [LANES-1:0]          lane_valid_q;
  lane_ctrl_t                ctrl_q   [LANES];
  logic [DATA_WIDTH-1:0]     result_q [LANES];
  logic [REG_ADDR_WIDTH-1:0] addr_q   [LANES];

  logic [LANES-1:0] valid_v, exc_v, eret_v, op_v, live, commit_v;
  logic             cp0_hit, ready_go, flush_exc_c, flush_eret_c;
  logic [IDX_W-1:0] cp0_idx;
  lane_ctrl_t       cp0_lane;
  cp0_req_t         cp0_req;

  // Stage payload: no reset needed, qualified by wb_valid
  always_ff @(posedge clock) begin
    if (io.io_valid && io.wb_allow_in) begin
      lane_valid_q <= io.io_lane_valid;
      for (int i = 0; i < int'(LANES); i++) begin
        ctrl_q[i].pc         <= io.io_pc[i*PC_W +: PC_W];
        ctrl_q[i].strobe     <= io.io_rf_strobe[i*STRB_W +: STRB_W];
        ctrl_q[i].rf_we      <= io.io_rf_we[i];
        ctrl_q[i].mfc0       <= io.io_mfc0[i];
        ctrl_q[i].mtc0       <= io.io_mtc0[i];
        ctrl_q[i].exc        <= io.io_exc[i];
        ctrl_q[i].eret       <= io.io_eret[i];
        ctrl_q[i].delay_slot <= io.io_delay_slot[i];
        ctrl_q[i].exc_code   <= io.io_exc_code[i*EXC_CODE_W +: EXC_CODE_W];
        ctrl_q[i].cp0_reg    <= io.io_cp0_reg[i*CP0_REG_W +: CP0_REG_W];
        ctrl_q[i].cp0_sel    <= io.io_cp0_sel[i*CP0_SEL_W +: CP0_SEL_W];
        result_q[i]          <= io.io_result[i*DATA_WIDTH +: DATA_WIDTH];
        addr_q[i]            <= io.io_rf_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      end
    end
  end

  // A flush pulse drops whatever the stage would otherwise accept
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid        <= 1'b0;
      flush_exception <= 1'b0;
      flush_eret      <= 1'b0;
    end else begin
      if (flush_exception || flush_eret) wb_valid <= 1'b0;
      else if (io.wb_allow_in)           wb_valid <= io.io_valid;
      flush_exception <= flush_exc_c;
      flush_eret      <= flush_eret_c;
    end
  end

  always_comb begin
    exc_v  = '0;
    eret_v = '0;
    op_v   = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      exc_v[i]  = ctrl_q[i].exc;
      eret_v[i] = ctrl_q[i].eret;
      op_v[i]   = ctrl_q[i].mfc0 || ctrl_q[i].mtc0 || ctrl_q[i].exc || ctrl_q[i].eret;
    end
    valid_v = lane_valid_q & {LANES{wb_valid}};
  end

  wb_lane_kill #(.LANES(LANES)) u_lane_kill (
    .lane_valid (valid_v),
    .exc        (exc_v),
    .eret       (eret_v),
    .cp0_op     (op_v),
    .live       (live),
    .cp0_hit    (cp0_hit),
    .cp0_idx    (cp0_idx)
  );

  assign ready_go       = !(wb_valid && cp0_busy && cp0_hit);
  assign io.wb_allow_in = !wb_valid || ready_go;

  // Register-file writes: a younger lane to the same non-zero register wins
  always_comb begin
    commit_v      = '0;
    rf_we         = '0;
    rf_addr       = '0;
    rf_strobe     = '0;
    rf_data       = '0;
    debug_pc      = '0;
    debug_rf_we   = '0;
    for (int i = 0; i < int'(LANES); i++)
      commit_v[i] = live[i] && ctrl_q[i].rf_we && !ctrl_q[i].exc;
    for (int i = 0; i < int'(LANES); i++) begin
      rf_we[i] = commit_v[i] && ready_go;
      for (int j = i + 1; j < int'(LANES); j++)
        if (commit_v[j] && addr_q[j] == addr_q[i] && addr_q[i] != '0) rf_we[i] = 1'b0;
      rf_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] = addr_q[i];
      rf_strobe[i*STRB_W +: STRB_W]               = ctrl_q[i].strobe;
      rf_data[i*DATA_WIDTH +: DATA_WIDTH]         = ctrl_q[i].mfc0 ? cp0_read_data : result_q[i];
      debug_pc[i*PC_W +: PC_W]                    = ctrl_q[i].pc;
      debug_rf_we[i*STRB_W +: STRB_W]             = {STRB_W{rf_we[i]}} & ctrl_q[i].strobe;
    end
  end

  assign debug_rf_addr = rf_addr;
  assign debug_rf_data = rf_data;

  // CP0 request from the oldest live lane touching CP0; exc outranks eret
  always_comb begin
    cp0_lane  = ctrl_q[cp0_idx];
    cp0_req   = '0;
    cp0_wdata = '0;
    if (cp0_hit) begin
      cp0_req.we        = cp0_lane.mtc0 && !cp0_lane.exc && ready_go;
      cp0_req.exc_valid = cp0_lane.exc;
      cp0_req.eret      = cp0_lane.eret && !cp0_lane.exc;
      cp0_req.bd        = cp0_lane.delay_slot;
      cp0_req.cp0_reg   = cp0_lane.cp0_reg;
      cp0_req.cp0_sel   = cp0_lane.cp0_sel;
      cp0_req.exc_code  = cp0_lane.exc_code;
      cp0_req.exc_pc    = cp0_lane.pc;
      cp0_wdata         = result_q[cp0_idx];
    end
    flush_exc_c  = cp0_req.exc_valid && ready_go;
    flush_eret_c = cp0_req.eret && ready_go;
  end

  assign cp0_we        = cp0_req.we;
  assign cp0_exc_valid = cp0_req.exc_valid;
  assign cp0_eret      = cp0_req.eret;
  assign cp0_bd        = cp0_req.bd;
  assign cp0_reg       = cp0_req.cp0_reg;
  assign cp0_sel       = cp0_req.cp0_sel;
  assign cp0_exc_code  = cp0_req.exc_code;
  assign cp0_exc_pc    = cp0_req.exc_pc;

`ifdef WB_RETIRE_COUNTER_EN
  always_ff @(posedge clock) begin
    if (reset)         retire_count <= '0;
    else if (ready_go) retire_count <= retire_count + 32'($countones(live & ~exc_v));
  end
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed bench for wb_commit_stage with a bundle-level reference model checked every cycle.
module tb_wb_commit_stage;
  localparam int unsigned L  = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  typedef struct {
    bit        lv, we, mfc0, mtc0, exc, eret, ds;
    bit [31:0] pc, res;
    bit [4:0]  addr, code, creg;
    bit [3:0]  strb;
    bit [2:0]  csel;
  } lane_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic            cp0_busy;
  logic [DW-1:0]   cp0_read_data;
  logic            cp0_we, cp0_exc_valid, cp0_eret, cp0_bd;
  logic [4:0]      cp0_reg, cp0_exc_code;
  logic [2:0]      cp0_sel;
  logic [31:0]     cp0_exc_pc;
  logic [DW-1:0]   cp0_wdata;
  logic [L-1:0]    rf_we;
  logic [L*AW-1:0] rf_addr, debug_rf_addr;
  logic [L*4-1:0]  rf_strobe, debug_rf_we;
  logic [L*DW-1:0] rf_data, debug_rf_data;
  logic [L*32-1:0] debug_pc;
  logic            flush_exception, flush_eret;
`ifdef WB_RETIRE_COUNTER_EN
  logic [31:0]     retire_count;
  bit   [31:0]     m_ret;
  int              m_rcnt;
`endif

  wb_commit_stage_if #(.LANES(L), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bif ();

  wb_commit_stage #(.LANES(L), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .io(bif),
    .cp0_busy(cp0_busy), .cp0_read_data(cp0_read_data),
    .cp0_we(cp0_we), .cp0_exc_valid(cp0_exc_valid), .cp0_eret(cp0_eret), .cp0_bd(cp0_bd),
    .cp0_reg(cp0_reg), .cp0_sel(cp0_sel), .cp0_exc_code(cp0_exc_code), .cp0_exc_pc(cp0_exc_pc),
    .cp0_wdata(cp0_wdata), .rf_we(rf_we), .rf_addr(rf_addr), .rf_strobe(rf_strobe),
    .rf_data(rf_data), .flush_exception(flush_exception), .flush_eret(flush_eret),
    .debug_pc(debug_pc), .debug_rf_we(debug_rf_we), .debug_rf_addr(debug_rf_addr),
    .debug_rf_data(debug_rf_data)
`ifdef WB_RETIRE_COUNTER_EN
    , .retire_count(retire_count)
`endif
  );

  int    vectors    = 0;
  int    miscompares = 0;
  bit    t_valid;
  lane_t t_ln [L];
  // model of the bundle currently held in the stage
  bit    m_valid, m_fx, m_fe, m_go;
  int    m_c;
  lane_t m_ln [L];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < int'(L); i++) t_ln[i] = '{default: '0};
  endtask

  task automatic wr(input int ln, input bit [4:0] a, input bit [31:0] d);
    t_ln[ln].lv = 1'b1; t_ln[ln].we = 1'b1; t_ln[ln].addr = a; t_ln[ln].res = d;
    t_ln[ln].strb = 4'hF; t_ln[ln].pc = 32'h8000_0000 + 32'(ln * 4);
  endtask

  task automatic drive();
    bif.io_valid = t_valid;
    for (int i = 0; i < int'(L); i++) begin
      bif.io_lane_valid[i]      = t_ln[i].lv;
      bif.io_pc[i*32 +: 32]     = t_ln[i].pc;
      bif.io_rf_we[i]           = t_ln[i].we;
      bif.io_rf_addr[i*AW +: AW] = t_ln[i].addr;
      bif.io_rf_strobe[i*4 +: 4] = t_ln[i].strb;
      bif.io_result[i*DW +: DW] = t_ln[i].res;
      bif.io_mfc0[i]            = t_ln[i].mfc0;
      bif.io_mtc0[i]            = t_ln[i].mtc0;
      bif.io_exc[i]             = t_ln[i].exc;
      bif.io_eret[i]            = t_ln[i].eret;
      bif.io_delay_slot[i]      = t_ln[i].ds;
      bif.io_exc_code[i*5 +: 5] = t_ln[i].code;
      bif.io_cp0_reg[i*5 +: 5]  = t_ln[i].creg;
      bif.io_cp0_sel[i*3 +: 3]  = t_ln[i].csel;
    end
  endtask

  // Expected outputs derived from the held bundle and the current CP0 inputs
  task automatic compare();
    int           first_kill, c;
    bit           live [L];
    bit           writes [L];
    bit           go;
    logic [L-1:0] e_we;
    logic [7:0]   e_dbg;
    bit [31:0]    d;
    first_kill = L;
    c = -1;
    for (int i = 0; i < int'(L); i++)
      if (first_kill == int'(L) && m_valid && m_ln[i].lv && (m_ln[i].exc || m_ln[i].eret)) first_kill = i;
    for (int i = 0; i < int'(L); i++) begin
      live[i]   = m_valid && m_ln[i].lv && i <= first_kill;
      writes[i] = live[i] && m_ln[i].we && !m_ln[i].exc;
      if (c < 0 && live[i] && (m_ln[i].mfc0 || m_ln[i].mtc0 || m_ln[i].exc || m_ln[i].eret)) c = i;
    end
    go = !(c >= 0 && cp0_busy);
    e_we = '0;
    e_dbg = '0;
    for (int i = 0; i < int'(L); i++) begin
      e_we[i] = go && writes[i];
      for (int j = i + 1; j < int'(L); j++)
        if (writes[j] && m_ln[j].addr == m_ln[i].addr && m_ln[i].addr != 0) e_we[i] = 1'b0;
      if (e_we[i]) e_dbg[i*4 +: 4] = m_ln[i].strb;
    end
    chk("allow_in", 64'(bif.wb_allow_in), 64'(!m_valid || go));
    chk("rf_we", 64'(rf_we), 64'(e_we));
    chk("debug_rf_we", 64'(debug_rf_we), 64'(e_dbg));
    for (int i = 0; i < int'(L); i++) begin
      if (m_valid) chk($sformatf("debug_pc%0d", i), 64'(debug_pc[i*32 +: 32]), 64'(m_ln[i].pc));
      if (e_we[i]) begin
        d = m_ln[i].mfc0 ? cp0_read_data : m_ln[i].res;
        chk($sformatf("rf_addr%0d", i), 64'(rf_addr[i*AW +: AW]), 64'(m_ln[i].addr));
        chk($sformatf("rf_data%0d", i), 64'(rf_data[i*DW +: DW]), 64'(d));
        chk($sformatf("debug_rf_data%0d", i), 64'(debug_rf_data[i*DW +: DW]), 64'(d));
      end
    end
    if (c >= 0) begin
      chk("cp0_we", 64'(cp0_we), 64'(m_ln[c].mtc0 && !m_ln[c].exc && go));
      chk("cp0_exc_valid", 64'(cp0_exc_valid), 64'(m_ln[c].exc));
      chk("cp0_eret", 64'(cp0_eret), 64'(m_ln[c].eret && !m_ln[c].exc));
      chk("cp0_exc_pc", 64'(cp0_exc_pc), 64'(m_ln[c].pc));
      chk("cp0_reg", 64'(cp0_reg), 64'(m_ln[c].creg));
      chk("cp0_wdata", 64'(cp0_wdata), 64'(m_ln[c].res));
    end else begin
      chk("cp0_idle", 64'({cp0_we, cp0_exc_valid, cp0_eret, cp0_bd, cp0_exc_pc}), 64'd0);
    end
    chk("flush_exception", 64'(flush_exception), 64'(m_fx));
    chk("flush_eret", 64'(flush_eret), 64'(m_fe));
`ifdef WB_RETIRE_COUNTER_EN
    chk("retire_count", 64'(retire_count), 64'(m_ret));
    m_rcnt = 0;
    if (go) for (int i = 0; i < int'(L); i++) if (live[i] && !m_ln[i].exc) m_rcnt++;
`endif
    m_go = go;
    m_c  = c;
  endtask

  task automatic advance();
    bit allow, nfx, nfe;
    allow = !m_valid || m_go;
    nfx = !reset && m_c >= 0 && m_go && m_ln[m_c].exc;
    nfe = !reset && m_c >= 0 && m_go && m_ln[m_c].eret && !m_ln[m_c].exc;
    if (reset || m_fx || m_fe) m_valid = 1'b0;
    else if (allow)            m_valid = t_valid;
    if (t_valid && allow) m_ln = t_ln;
    m_fx = nfx;
    m_fe = nfe;
`ifdef WB_RETIRE_COUNTER_EN
    m_ret = reset ? 32'd0 : m_ret + 32'(m_rcnt);
`endif
  endtask

  task automatic cycle();
    @(negedge clock);
    compare();
    @(posedge clock);
    advance();
    #1;
  endtask

  task automatic offer(input bit v);
    t_valid = v;
    drive();
  endtask

  initial begin
    reset = 1'b1; cp0_busy = 1'b0; cp0_read_data = '0;
    t_valid = 1'b0; clear_lanes(); drive();
    m_valid = 1'b0; m_fx = 1'b0; m_fe = 1'b0; m_go = 1'b1; m_c = -1; m_ln = t_ln;
`ifdef WB_RETIRE_COUNTER_EN
    m_ret = '0; m_rcnt = 0;
`endif
    cycle(); cycle();
    reset = 1'b0;
    #1;
    chk("rst_allow_in", 64'(bif.wb_allow_in), 64'd1);
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_cp0", 64'({cp0_we, cp0_exc_valid, cp0_eret}), 64'd0);
    chk("rst_flush", 64'({flush_exception, flush_eret}), 64'd0);

    // two independent writes
    clear_lanes(); wr(0, 5'd3, 32'd5); wr(1, 5'd4, 32'd7); offer(1); cycle();
    offer(0); #1;
    chk("dual_rf_we", 64'(rf_we), 64'b11);
    chk("dual_data0", 64'(rf_data[31:0]), 64'd5);
    chk("dual_data1", 64'(rf_data[63:32]), 64'd7);
    chk("dual_debug_we", 64'(debug_rf_we), 64'hFF);
    cycle();

    // same register from both lanes: younger wins
    clear_lanes(); wr(0, 5'd5, 32'd1); wr(1, 5'd5, 32'd2); offer(1); cycle();
    offer(0); #1;
    chk("waw_rf_we", 64'(rf_we), 64'b10);
    chk("waw_data1", 64'(rf_data[63:32]), 64'd2);
    cycle();

    // exception on lane 0 kills lane 1 and drops the bundle offered during the flush
    clear_lanes(); wr(1, 5'd4, 32'd9);
    t_ln[0].lv = 1'b1; t_ln[0].exc = 1'b1; t_ln[0].code = 5'h0C; t_ln[0].pc = 32'hBFC0_0100;
    offer(1); cycle();
    offer(0); #1;
    chk("exc_rf_we", 64'(rf_we), 64'd0);
    chk("exc_valid", 64'(cp0_exc_valid), 64'd1);
    chk("exc_pc", 64'(cp0_exc_pc), 64'hBFC0_0100);
    chk("exc_code", 64'(cp0_exc_code), 64'h0C);
    cycle();
    chk("exc_flush_pulse", 64'(flush_exception), 64'd1);
    clear_lanes(); wr(0, 5'd6, 32'd9); offer(1); cycle();
    offer(0); #1;
    chk("exc_flush_end", 64'(flush_exception), 64'd0);
    chk("exc_dropped", 64'(rf_we), 64'd0);
    cycle();

    // mfc0 on lane 1 held by a busy CP0 for three cycles
    clear_lanes(); wr(0, 5'd7, 32'h11); wr(1, 5'd8, 32'hDEAD);
    t_ln[1].mfc0 = 1'b1; t_ln[1].creg = 5'd12;
    cp0_busy = 1'b1; cp0_read_data = 32'hCAFE_0001;
    offer(1); cycle();
    offer(0);
    for (int n = 0; n < 3; n++) begin
      #1;
      chk("stall_allow", 64'(bif.wb_allow_in), 64'd0);
      chk("stall_rf_we", 64'(rf_we), 64'd0);
      cycle();
    end
    cp0_busy = 1'b0; #1;
    chk("mfc0_rf_we", 64'(rf_we), 64'b11);
    chk("mfc0_data1", 64'(rf_data[63:32]), 64'hCAFE_0001);
    chk("mfc0_data0", 64'(rf_data[31:0]), 64'h11);
    cycle();

    // eret on lane 0
    clear_lanes(); wr(1, 5'd9, 32'd3);
    t_ln[0].lv = 1'b1; t_ln[0].eret = 1'b1; t_ln[0].pc = 32'h8000_0010;
    offer(1); cycle();
    offer(0); #1;
    chk("eret_rf_we", 64'(rf_we), 64'd0);
    chk("eret_cp0", 64'(cp0_eret), 64'd1);
    cycle();
    chk("eret_flush_pulse", 64'(flush_eret), 64'd1);
    cycle();
    chk("eret_flush_end", 64'(flush_eret), 64'd0);

    // mtc0 on lane 0 with a normal write on lane 1
    clear_lanes(); wr(1, 5'd10, 32'd3);
    t_ln[0].lv = 1'b1; t_ln[0].mtc0 = 1'b1; t_ln[0].creg = 5'd12; t_ln[0].res = 32'h1234;
    offer(1); cycle();
    offer(0); #1;
    chk("mtc0_we", 64'(cp0_we), 64'd1);
    chk("mtc0_wdata", 64'(cp0_wdata), 64'h1234);
    chk("mtc0_rf_we", 64'(rf_we), 64'b10);
    cycle();

    // exc and eret together on lane 1: exception wins
    clear_lanes(); wr(0, 5'd2, 32'd4);
    t_ln[1].lv = 1'b1; t_ln[1].exc = 1'b1; t_ln[1].eret = 1'b1; t_ln[1].we = 1'b1;
    t_ln[1].addr = 5'd2; t_ln[1].pc = 32'h8000_0104;
    offer(1); cycle();
    offer(0); #1;
    chk("exer_rf_we", 64'(rf_we), 64'b01);
    chk("exer_eret", 64'(cp0_eret), 64'd0);
    cycle();
    chk("exer_flush", 64'({flush_exception, flush_eret}), 64'b10);
    cycle();

    // register 0 from both lanes is not treated as a conflict
    clear_lanes(); wr(0, 5'd0, 32'd1); wr(1, 5'd0, 32'd2); offer(1); cycle();
    offer(0); #1;
    chk("r0_rf_we", 64'(rf_we), 64'b11);
    cycle();

    // reset while stalled on a busy CP0 discards the bundle
    clear_lanes(); wr(0, 5'd11, 32'd1); t_ln[0].mfc0 = 1'b1;
    cp0_busy = 1'b1; offer(1); cycle();
    offer(0); #1;
    chk("rst_stall_allow", 64'(bif.wb_allow_in), 64'd0);
    reset = 1'b1; cycle();
    reset = 1'b0; cp0_busy = 1'b0; #1;
    chk("rst_stall_rf_we", 64'(rf_we), 64'd0);
    chk("rst_stall_allow_in", 64'(bif.wb_allow_in), 64'd1);
    chk("rst_stall_cp0", 64'({cp0_we, cp0_exc_valid, cp0_eret}), 64'd0);
    cycle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
